// File: rtl/ibex_pkg.sv
// Shared types for the register-file write path.
package ibex_pkg;

  typedef enum logic [1:0] {
    RF_WR_SRC_NONE = 2'd0,
    RF_WR_SRC_LSU  = 2'd1,
    RF_WR_SRC_ID   = 2'd2,
    RF_WR_SRC_AUX  = 2'd3
  } rf_wr_src_e;

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rf_wr_req_t;

  localparam int unsigned RfWrReqW = $bits(rf_wr_req_t);

endpackage

// File: rtl/ibex_rf_wr_aux_fifo.sv
// Small FIFO buffering late auxiliary register-file writes.
module ibex_rf_wr_aux_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 37
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic [Width-1:0] mem_q [Depth];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Payload storage is deliberately left unreset; validity comes from cnt_q.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) push_i |-> !full_o);
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) pop_i |-> !empty_o);
`endif

endmodule

// File: rtl/ibex_rf_wr_arbiter.sv
// Arbitrates the register-file write port between LSU, ID/EX and a buffered
// auxiliary unit, and tracks outstanding auxiliary writes per register.
module ibex_rf_wr_arbiter
  import ibex_pkg::*;
#(
  parameter int unsigned AuxDepth    = 2,
  parameter int unsigned StarveLimit = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lsu_we_i,
  input  logic [4:0]  lsu_waddr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic        id_we_i,
  input  logic [4:0]  id_waddr_i,
  input  logic [31:0] id_wdata_i,
  output logic        id_ready_o,
  input  logic        aux_issue_i,
  input  logic [4:0]  aux_issue_waddr_i,
  input  logic        aux_valid_i,
  input  logic [4:0]  aux_waddr_i,
  input  logic [31:0] aux_wdata_i,
  output logic        aux_ready_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic [1:0]  rf_wr_src_o,
  output logic [31:0] aux_pending_o,
  output logic        aux_starved_o
);

  localparam int unsigned StarveW = $clog2(StarveLimit + 1);

  logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [RfWrReqW-1:0] fifo_wdata, fifo_rdata;
  rf_wr_req_t         head;
  rf_wr_src_e         wr_src;
  logic               grant_aux;
  logic [StarveW-1:0] wait_q;
  logic [31:0]        pending_q, pending_d;

  assign fifo_wdata = {aux_waddr_i, aux_wdata_i};
  assign fifo_push  = aux_valid_i & aux_ready_o;
  assign fifo_pop   = grant_aux;
  assign head       = fifo_rdata;

  ibex_rf_wr_aux_fifo #(
    .Depth (AuxDepth),
    .Width (RfWrReqW)
  ) u_aux_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign aux_ready_o   = ~fifo_full;
  assign aux_starved_o = ~fifo_empty & (wait_q >= StarveW'(StarveLimit));
  assign id_ready_o    = ~lsu_we_i & ~aux_starved_o;

  // LSU can never stall, so it outranks a starved auxiliary head.
  always_comb begin
    wr_src     = RF_WR_SRC_NONE;
    grant_aux  = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (lsu_we_i) begin
      wr_src     = RF_WR_SRC_LSU;
      rf_waddr_o = lsu_waddr_i;
      rf_wdata_o = lsu_wdata_i;
    end else if (aux_starved_o) begin
      wr_src     = RF_WR_SRC_AUX;
      grant_aux  = 1'b1;
      rf_waddr_o = head.waddr;
      rf_wdata_o = head.wdata;
    end else if (id_we_i) begin
      wr_src     = RF_WR_SRC_ID;
      rf_waddr_o = id_waddr_i;
      rf_wdata_o = id_wdata_i;
    end else if (!fifo_empty) begin
      wr_src     = RF_WR_SRC_AUX;
      grant_aux  = 1'b1;
      rf_waddr_o = head.waddr;
      rf_wdata_o = head.wdata;
    end
  end

  assign rf_we_o     = (wr_src != RF_WR_SRC_NONE) & (rf_waddr_o != 5'd0);
  assign rf_wr_src_o = wr_src;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_q <= '0;
    end else if (fifo_empty || fifo_pop) begin
      wait_q <= '0;
    end else if (wait_q < StarveW'(StarveLimit)) begin
      wait_q <= wait_q + StarveW'(1);
    end
  end

  // A new issue to the register being retired this cycle must stay pending.
  always_comb begin
    pending_d = pending_q;
    if (grant_aux)   pending_d[head.waddr] = 1'b0;
    if (aux_issue_i) pending_d[aux_issue_waddr_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pending_q <= '0;
    else         pending_q <= pending_d;
  end

  assign aux_pending_o = pending_q;

`ifndef SYNTHESIS
  a_issue_not_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (aux_issue_i && aux_issue_waddr_i != 5'd0) |->
      (!pending_q[aux_issue_waddr_i] || (grant_aux && head.waddr == aux_issue_waddr_i)));
  a_aux_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (aux_valid_i && !aux_ready_o) |=>
      (aux_valid_i && $stable(aux_waddr_i) && $stable(aux_wdata_i)));
  c_lsu_vs_starved_full: cover property (@(posedge clk_i) disable iff (!rst_ni)
    lsu_we_i && fifo_full && aux_starved_o);
`endif

endmodule

// File: tb/tb_ibex_rf_wr_arbiter.sv
// Directed bench for ibex_rf_wr_arbiter with a queue-based reference model.
module tb_ibex_rf_wr_arbiter;
  import ibex_pkg::*;

  localparam int DEPTH  = 2;
  localparam int STARVE = 4;

  logic        clk_i, rst_ni;
  logic        lsu_we_i, id_we_i, aux_issue_i, aux_valid_i;
  logic [4:0]  lsu_waddr_i, id_waddr_i, aux_issue_waddr_i, aux_waddr_i;
  logic [31:0] lsu_wdata_i, id_wdata_i, aux_wdata_i;
  logic        id_ready_o, aux_ready_o, rf_we_o, aux_starved_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o, aux_pending_o;
  logic [1:0]  rf_wr_src_o;

  int checks = 0;
  int errors = 0;

  ibex_rf_wr_arbiter #(.AuxDepth(DEPTH), .StarveLimit(STARVE)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .lsu_we_i(lsu_we_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
    .id_we_i(id_we_i), .id_waddr_i(id_waddr_i), .id_wdata_i(id_wdata_i),
    .id_ready_o(id_ready_o),
    .aux_issue_i(aux_issue_i), .aux_issue_waddr_i(aux_issue_waddr_i),
    .aux_valid_i(aux_valid_i), .aux_waddr_i(aux_waddr_i), .aux_wdata_i(aux_wdata_i),
    .aux_ready_o(aux_ready_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .rf_wr_src_o(rf_wr_src_o), .aux_pending_o(aux_pending_o),
    .aux_starved_o(aux_starved_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(
    input logic lw, input logic [4:0] la, input logic [31:0] ld,
    input logic iw, input logic [4:0] ia, input logic [31:0] idat,
    input logic is, input logic [4:0] isa,
    input logic av, input logic [4:0] aa, input logic [31:0] ad);
    lsu_we_i = lw; lsu_waddr_i = la; lsu_wdata_i = ld;
    id_we_i = iw; id_waddr_i = ia; id_wdata_i = idat;
    aux_issue_i = is; aux_issue_waddr_i = isa;
    aux_valid_i = av; aux_waddr_i = aa; aux_wdata_i = ad;
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reference model: queued results, a starvation age and a pending bitmap.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;
  ent_t        mq[$];
  int          mwait = 0;
  logic [31:0] mpend = '0;

  rf_wr_src_e  e_src;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  logic        e_we, e_starved, popped;
  int          sz;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      mq.delete();
      mwait = 0;
      mpend = '0;
      checkOutput("m_rst_rf_we", rf_we_o, 0);
      checkOutput("m_rst_aux_ready", aux_ready_o, 1);
      checkOutput("m_rst_id_ready", id_ready_o, 1);
      checkOutput("m_rst_starved", aux_starved_o, 0);
      checkOutput("m_rst_src", rf_wr_src_o, RF_WR_SRC_NONE);
      checkOutput("m_rst_pending", aux_pending_o, 0);
    end else begin
      sz        = mq.size();
      e_starved = (sz > 0) && (mwait >= STARVE);
      e_addr    = '0;
      e_data    = '0;
      if (lsu_we_i) begin
        e_src = RF_WR_SRC_LSU; e_addr = lsu_waddr_i; e_data = lsu_wdata_i;
      end else if (e_starved || (!id_we_i && sz > 0)) begin
        e_src = RF_WR_SRC_AUX; e_addr = mq[0].a; e_data = mq[0].d;
      end else if (id_we_i) begin
        e_src = RF_WR_SRC_ID; e_addr = id_waddr_i; e_data = id_wdata_i;
      end else begin
        e_src = RF_WR_SRC_NONE;
      end
      e_we = (e_src != RF_WR_SRC_NONE) && (e_addr != 0);

      checkOutput("m_rf_we", rf_we_o, e_we);
      checkOutput("m_aux_ready", aux_ready_o, sz < DEPTH);
      checkOutput("m_id_ready", id_ready_o, !lsu_we_i && !e_starved);
      checkOutput("m_starved", aux_starved_o, e_starved);
      checkOutput("m_pending", aux_pending_o, mpend);
      if (e_we) begin
        checkOutput("m_waddr", rf_waddr_o, e_addr);
        checkOutput("m_wdata", rf_wdata_o, e_data);
        checkOutput("m_src", rf_wr_src_o, e_src);
      end else if (e_src == RF_WR_SRC_NONE) begin
        checkOutput("m_src_none", rf_wr_src_o, RF_WR_SRC_NONE);
      end

      popped = (e_src == RF_WR_SRC_AUX);
      if (popped) begin
        if (mq[0].a != 0) mpend[mq[0].a] = 1'b0;
        void'(mq.pop_front());
      end
      if (aux_issue_i && aux_issue_waddr_i != 0) mpend[aux_issue_waddr_i] = 1'b1;
      if (sz == 0 || popped) mwait = 0;
      else if (mwait < STARVE) mwait = mwait + 1;
      if (aux_valid_i && sz < DEPTH) mq.push_back('{a: aux_waddr_i, d: aux_wdata_i});
    end
  end

  bit exp_rdy[8] = '{1, 1, 0, 0, 0, 0, 1, 0};

  initial begin
    int k;
    rst_ni = 1'b0;
    idle();
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_rf_we", rf_we_o, 0);
    checkOutput("rst_aux_ready", aux_ready_o, 1);
    checkOutput("rst_id_ready", id_ready_o, 1);
    checkOutput("rst_src", rf_wr_src_o, RF_WR_SRC_NONE);
    checkOutput("rst_pending", aux_pending_o, 0);
    rst_ni = 1'b1;
    step();

    // Issue x5, then its result, then it retires.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    step();
    checkOutput("t1_pend5_set", aux_pending_o[5], 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF);
    checkOutput("t1_no_bypass", rf_we_o, 0);
    step();
    idle();
    checkOutput("t1_we", rf_we_o, 1);
    checkOutput("t1_waddr", rf_waddr_o, 5);
    checkOutput("t1_wdata", rf_wdata_o, 32'hDEADBEEF);
    checkOutput("t1_src", rf_wr_src_o, RF_WR_SRC_AUX);
    step();
    checkOutput("t1_pend5_clr", aux_pending_o[5], 0);
    checkOutput("t1_we_after", rf_we_o, 0);

    // LSU beats ID and a buffered aux result; ID then wins.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h11112222);
    step();
    applyStimulus(1, 3, 32'hAAAA0003, 1, 4, 32'hBBBB0004, 0, 0, 0, 0, 0);
    checkOutput("t2_lsu_src", rf_wr_src_o, RF_WR_SRC_LSU);
    checkOutput("t2_lsu_addr", rf_waddr_o, 3);
    checkOutput("t2_id_stall", id_ready_o, 0);
    step();
    applyStimulus(0, 0, 0, 1, 4, 32'hBBBB0004, 0, 0, 0, 0, 0);
    checkOutput("t2_id_src", rf_wr_src_o, RF_WR_SRC_ID);
    checkOutput("t2_id_data", rf_wdata_o, 32'hBBBB0004);
    checkOutput("t2_id_ready", id_ready_o, 1);
    step();
    idle();
    checkOutput("t2_aux_addr", rf_waddr_o, 9);
    checkOutput("t2_aux_src", rf_wr_src_o, RF_WR_SRC_AUX);
    step();

    // ID saturates the port while one aux result waits.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 10, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 1, 6, 32'h600, 0, 0, 1, 10, 32'h10101010);
    step();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 1, 6, 32'h601 + i, 0, 0, 0, 0, 0);
      checkOutput("t3_id_wins", rf_wr_src_o, RF_WR_SRC_ID);
      checkOutput("t3_not_starved", aux_starved_o, 0);
      step();
    end
    applyStimulus(0, 0, 0, 1, 6, 32'h605, 0, 0, 0, 0, 0);
    checkOutput("t3_starved", aux_starved_o, 1);
    checkOutput("t3_id_stall", id_ready_o, 0);
    checkOutput("t3_aux_addr", rf_waddr_o, 10);
    checkOutput("t3_aux_data", rf_wdata_o, 32'h10101010);
    step();
    checkOutput("t3_unstarved", aux_starved_o, 0);
    checkOutput("t3_id_again", rf_wr_src_o, RF_WR_SRC_ID);
    step();

    // Continuous aux results against a saturating ID.
    k = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(0, 0, 0, 1, 6, 32'h700 + c, 0, 0, 1, 5'(16 + k), 32'hA0000000 + k);
      checkOutput("t4_ready", aux_ready_o, exp_rdy[c]);
      checkOutput("t4_starved", aux_starved_o, c == 5);
      if (c == 5) checkOutput("t4_starve_addr", rf_waddr_o, 16);
      step();
      if (exp_rdy[c]) k++;
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'(16 + k), 32'hA0000000 + k);
    checkOutput("t4_drain_full", aux_ready_o, 0);
    checkOutput("t4_drain_addr", rf_waddr_o, 17);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'(16 + k), 32'hA0000000 + k);
    checkOutput("t4_pushpop_ready", aux_ready_o, 1);
    checkOutput("t4_pushpop_addr", rf_waddr_o, 18);
    step();
    idle();
    checkOutput("t4_last_addr", rf_waddr_o, 19);
    checkOutput("t4_last_data", rf_wdata_o, 32'hA0000003);
    step();
    checkOutput("t4_empty_we", rf_we_o, 0);

    // Writes to x0 are consumed but never reach the register file.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'h0BAD0BAD);
    step();
    idle();
    checkOutput("t5_aux_x0_we", rf_we_o, 0);
    checkOutput("t5_pend0", aux_pending_o, 0);
    step();
    applyStimulus(0, 0, 0, 1, 0, 32'h12345678, 0, 0, 0, 0, 0);
    checkOutput("t5_id_x0_ready", id_ready_o, 1);
    checkOutput("t5_id_x0_we", rf_we_o, 0);
    checkOutput("t5_aux_ready", aux_ready_o, 1);
    step();

    // Re-issue of x7 in the cycle its previous result retires.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h77777777);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    checkOutput("t6_x7_written", rf_waddr_o, 7);
    step();
    checkOutput("t6_pend7_kept", aux_pending_o, 32'h00000080);

    // Fill the FIFO behind LSU traffic, then reset mid-stream.
    applyStimulus(1, 1, 32'h1, 0, 0, 0, 1, 20, 1, 20, 32'h20202020);
    step();
    applyStimulus(1, 2, 32'h2, 0, 0, 0, 1, 21, 1, 21, 32'h21212121);
    step();
    idle();
    checkOutput("t6_full", aux_ready_o, 0);
    checkOutput("t6_pend_bits", aux_pending_o, 32'h00300080);
    rst_ni = 1'b0;
    #1;
    checkOutput("t6_rst_pending", aux_pending_o, 0);
    checkOutput("t6_rst_ready", aux_ready_o, 1);
    checkOutput("t6_rst_we", rf_we_o, 0);
    step();
    step();
    rst_ni = 1'b1;
    step();
    checkOutput("t6_post_we", rf_we_o, 0);
    checkOutput("t6_post_src", rf_wr_src_o, RF_WR_SRC_NONE);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibex_rf_wr_arbiter.md
Name: ibex_rf_wr_arbiter

Overview:
Shares the single register-file write port between three producers: LSU load data, the ID/EX result (writeback path), and a late-completing auxiliary unit (external coprocessor or multi-cycle unit). LSU writes are never stalled. ID and auxiliary writes are arbitrated, and auxiliary results are buffered in a small FIFO. A per-register pending scoreboard for in-flight auxiliary writes is exported to ID/EX for RAW/WAW hazard detection. The block sits between the writeback stage outputs and the register file write port.

Parameters:
AuxDepth, 2, auxiliary result FIFO entries (power of two, ≥1)
StarveLimit, 4, cycles an auxiliary FIFO head may wait before it pre-empts ID (≥1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
lsu_we_i  in  1  LSU load-data write request, must be accepted this cycle
lsu_waddr_i  in  5  LSU destination register
lsu_wdata_i  in  32  LSU load data
id_we_i  in  1  ID/EX result write request
id_waddr_i  in  5  ID/EX destination register
id_wdata_i  in  32  ID/EX result
id_ready_o  out  1  ID write accepted this cycle; low = ID/EX must hold
aux_issue_i  in  1  auxiliary op issued; sets scoreboard bit
aux_issue_waddr_i  in  5  destination of issued auxiliary op
aux_valid_i  in  1  auxiliary result valid
aux_waddr_i  in  5  auxiliary result destination
aux_wdata_i  in  32  auxiliary result data
aux_ready_o  out  1  FIFO can accept a result
rf_we_o  out  1  register file write enable
rf_waddr_o  out  5  register file write address
rf_wdata_o  out  32  register file write data
rf_wr_src_o  out  2  ibex_pkg::rf_wr_src_e of the current write (trace/debug)
aux_pending_o  out  32  bit n set = auxiliary write to xn outstanding
aux_starved_o  out  1  starvation pre-emption active this cycle

Behaviour:
- Reset (async, rst_ni low): FIFO empty, wait counter 0, aux_pending_o = 0. Consequently rf_we_o = 0, aux_ready_o = 1, id_ready_o = 1, aux_starved_o = 0, rf_wr_src_o = RF_WR_SRC_NONE. Reset mid-operation discards buffered results and pending bits.
- aux_ready_o = ~full (registered state only, no combinational path from pop). Push occurs when aux_valid_i & aux_ready_o. Push-to-earliest-write latency is 1 cycle. There is no bypass.
- Grant is combinational and fixed-priority:
  1. LSU if lsu_we_i.
  2. Otherwise the auxiliary head if FIFO non-empty and aux_starved_o.
  3. Otherwise ID if id_we_i.
  4. Otherwise the auxiliary head if non-empty.
- aux_starved_o = non-empty & (wait_cnt ≥ StarveLimit).
- id_ready_o = ~lsu_we_i & ~(aux_starved_o & non-empty). It is also high when id_we_i = 0.
- Pop occurs when the auxiliary head is granted. Push and pop in the same cycle are allowed (occupancy unchanged). Pointers wrap modulo AuxDepth.
- wait_cnt counts consecutive cycles the FIFO is non-empty without a pop. It saturates at StarveLimit and clears on pop or when the FIFO is empty. Width is $clog2(StarveLimit+1).
- Writes with address 0 are granted and consumed normally, but rf_we_o is forced low.
- Scoreboard:
  - Set bit aux_issue_waddr_i on aux_issue_i.
  - Clear bit rf_waddr_o when the auxiliary head is written.
  - If set and clear hit the same bit in one cycle, set wins.
  - Bit 0 is always 0.
  - The issuer must not issue to a register whose bit is already set (asserted).
- Assertions:
  - lsu_we_i must not coincide with a full FIFO whose head is starved. LSU still wins; this check is a cover only.
  - aux_valid_i & ~aux_ready_o implies aux_valid_i is held with stable data the next cycle.
  - No push when full.

Decomposition:
- ibex_pkg adds rf_wr_src_e, 2 bits: RF_WR_SRC_NONE, RF_WR_SRC_LSU, RF_WR_SRC_ID, RF_WR_SRC_AUX.
- Sub-module ibex_rf_wr_aux_fifo: parameterised depth, {waddr, wdata} payload, push/pop/full/empty, async reset of pointers only, storage without reset.
- Arbitration, starvation counter and scoreboard stay in the top module.

Test Plan:
- Reset, then aux_issue x5, then aux result x5 = 0xDEADBEEF with no ID/LSU traffic → aux_pending_o[5] set on the issue cycle; one cycle after push: rf_we_o = 1, rf_waddr_o = 5, src = AUX; pending[5] = 0 the next cycle.
- lsu_we_i, id_we_i and a non-empty FIFO in the same cycle → LSU written, id_ready_o = 0, FIFO occupancy unchanged; next cycle ID wins.
- id_we_i held high every cycle with one buffered aux result, StarveLimit = 4 → ID wins 4 cycles, then aux_starved_o = 1, id_ready_o = 0, aux written on cycle 5, wait_cnt cleared.
- Continuous aux_valid_i with AuxDepth = 2 while ID saturates the port → aux_ready_o drops after 2 pushes and returns 1 after the first pop; push and pop in the same cycle keep occupancy at 2.
- Aux result to x0 and ID result to x0 → handshakes complete, rf_we_o stays 0, pending bit 0 never set.
- Issue x7 while the x7 result is written in the same cycle → pending[7] remains 1. Asserting rst_ni mid-stream with 2 entries buffered → FIFO empty and aux_pending_o = 0 immediately.
